// File: rtl/if_id_skid_register.sv
// ----------------------------------------------------------------------------
// if_id_skid_register
//   IF/ID pipeline register with a valid/ready handshake on both sides and a
//   2-entry skid buffer. While decode is stalled, a fetched beat is parked in
//   the skid entry, so no beat is lost. IF_ready is a flop, which keeps ID
//   back-pressure from reaching fetch through a combinational path. Reset and
//   flush both empty the stage, and the decoder then sees a NOP bubble.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   EMPTY | no beat held; ID shows NOP bubble; IF_ready=1
//   FULL  | one beat in main register; ID_valid=1; IF_ready=1
//   SKID  | main + skid both hold beats; ID_valid=1; IF_ready=0
//
// Ports
//   clk, reset (async, active-high), flush (sync)
//   IF_*  : upstream fetch beat (valid/ready, pc, pc+4, instr, branch flag)
//   ID_*  : downstream decode beat (valid/ready, pc, pc+4, instr, branch flag)
//   occupancy : number of held beats (0..2)
// ----------------------------------------------------------------------------
module if_id_skid_register #(
    parameter int                 XLEN    = 32,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] NOP     = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               IF_valid,
    output logic               IF_ready,
    input  logic [XLEN-1:0]    IF_pc,
    input  logic [XLEN-1:0]    IF_pc_plus_4,
    input  logic [INSTR_W-1:0] IF_instruction,
    input  logic               IF_branch_estimation,
    output logic               ID_valid,
    input  logic               ID_ready,
    output logic [XLEN-1:0]    ID_pc,
    output logic [XLEN-1:0]    ID_pc_plus_4,
    output logic [INSTR_W-1:0] ID_instruction,
    output logic               ID_branch_estimation,
    output logic [1:0]         occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    pc_plus_4;
        logic [INSTR_W-1:0] instruction;
        logic               branch_estimation;
    } beat_t;

    // The bubble carries NOP in the instruction field and zero in all others.
    localparam beat_t BUBBLE = '{pc: '0, pc_plus_4: '0, instruction: NOP,
                                 branch_estimation: 1'b0};
    localparam beat_t ZERO   = '0;

    state_t     state_q, state_d;
    beat_t      main_q, main_d;
    beat_t      skid_q, skid_d;
    logic       if_ready_q, if_ready_d;
    logic       id_valid_q, id_valid_d;
    logic [1:0] occupancy_q, occupancy_d;

    beat_t if_beat;
    logic  accept;
    logic  drain;

    assign if_beat = '{pc: IF_pc, pc_plus_4: IF_pc_plus_4,
                       instruction: IF_instruction,
                       branch_estimation: IF_branch_estimation};

    assign accept = IF_valid & if_ready_q;
    assign drain  = id_valid_q & ID_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // A beat accepted or drained in this cycle is discarded.
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = ZERO;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        main_d  = if_beat;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_d = if_beat;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = if_beat;
                    end else if (drain) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                SKID: begin
                    // IF_ready is low here, so only a drain can occur.
                    if (drain) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = ZERO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = ZERO;
                end
            endcase
        end

        if_ready_d = (state_d != SKID);
        id_valid_d = (state_d != EMPTY);
        case (state_d)
            FULL:    occupancy_d = 2'd1;
            SKID:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= ZERO;
            if_ready_q  <= 1'b1;
            id_valid_q  <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            if_ready_q  <= if_ready_d;
            id_valid_q  <= id_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign IF_ready             = if_ready_q;
    assign ID_valid             = id_valid_q;
    assign ID_pc                = main_q.pc;
    assign ID_pc_plus_4         = main_q.pc_plus_4;
    assign ID_instruction       = main_q.instruction;
    assign ID_branch_estimation = main_q.branch_estimation;
    assign occupancy            = occupancy_q;

endmodule

// File: tb/tb_if_id_skid_register.sv
// ----------------------------------------------------------------------------
// tb_if_id_skid_register
//   Bench for if_id_skid_register. A queue-based model of the stage (a FIFO
//   of at most two beats) predicts the outputs, and a compare process checks
//   them on every cycle out of reset. Directed steps add literal checks that
//   pin the model.
// ----------------------------------------------------------------------------
module tb_if_id_skid_register;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        be;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        IF_valid = 1'b0;
    logic        IF_ready;
    logic [31:0] IF_pc = '0;
    logic [31:0] IF_pc_plus_4 = '0;
    logic [31:0] IF_instruction = '0;
    logic        IF_branch_estimation = 1'b0;
    logic        ID_valid;
    logic        ID_ready = 1'b0;
    logic [31:0] ID_pc;
    logic [31:0] ID_pc_plus_4;
    logic [31:0] ID_instruction;
    logic        ID_branch_estimation;
    logic [1:0]  occupancy;

    int n_cmp  = 0;
    int n_fail = 0;

    beat_t mq[$];
    logic  m_acc, m_drn;

    if_id_skid_register dut (
        .clk                  (clk),
        .reset                (reset),
        .flush                (flush),
        .IF_valid             (IF_valid),
        .IF_ready             (IF_ready),
        .IF_pc                (IF_pc),
        .IF_pc_plus_4         (IF_pc_plus_4),
        .IF_instruction       (IF_instruction),
        .IF_branch_estimation (IF_branch_estimation),
        .ID_valid             (ID_valid),
        .ID_ready             (ID_ready),
        .ID_pc                (ID_pc),
        .ID_pc_plus_4         (ID_pc_plus_4),
        .ID_instruction       (ID_instruction),
        .ID_branch_estimation (ID_branch_estimation),
        .occupancy            (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: FIFO of up to two beats. Head is what ID sees; IF may push only
    // while fewer than two beats are held.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            m_acc = IF_valid && (mq.size() != 2);
            m_drn = (mq.size() != 0) && ID_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) mq.push_back('{pc: IF_pc, pc4: IF_pc_plus_4,
                                          instr: IF_instruction,
                                          be: IF_branch_estimation});
            end
        end
    end

    always @(posedge clk) begin
        #3;
        if (!reset) begin
            if (mq.size() != 0) begin
                check("cmp_valid", {31'd0, ID_valid}, 32'd1);
                check("cmp_pc", ID_pc, mq[0].pc);
                check("cmp_pc4", ID_pc_plus_4, mq[0].pc4);
                check("cmp_instr", ID_instruction, mq[0].instr);
                check("cmp_be", {31'd0, ID_branch_estimation}, {31'd0, mq[0].be});
            end else begin
                check("cmp_valid", {31'd0, ID_valid}, 32'd0);
                check("cmp_pc", ID_pc, 32'd0);
                check("cmp_pc4", ID_pc_plus_4, 32'd0);
                check("cmp_instr", ID_instruction, NOP);
                check("cmp_be", {31'd0, ID_branch_estimation}, 32'd0);
            end
            check("cmp_occ", {30'd0, occupancy}, mq.size());
            check("cmp_ready", {31'd0, IF_ready}, (mq.size() != 2) ? 32'd1 : 32'd0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic be);
        IF_valid             = v;
        IF_pc                = pc;
        IF_pc_plus_4         = pc + 32'd4;
        IF_instruction       = pc ^ 32'hA5A5_0000;
        IF_branch_estimation = be;
    endtask

    initial begin
        // 1. Reset
        #1 reset = 1'b1;
        #29 reset = 1'b0;
        #1;
        check("rst_valid", {31'd0, ID_valid}, 32'd0);
        check("rst_instr", ID_instruction, 32'h0000_0013);
        check("rst_pc", ID_pc, 32'd0);
        check("rst_ready", {31'd0, IF_ready}, 32'd1);
        check("rst_occ", {30'd0, occupancy}, 32'd0);
        cycle();

        // 2. Streaming
        ID_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'(4 * i), 1'b0);
            IF_instruction = 32'h2bc0_0093;
            cycle();
            check("stream_pc", ID_pc, 32'(4 * i));
            check("stream_instr", ID_instruction, 32'h2bc0_0093);
            check("stream_valid", {31'd0, ID_valid}, 32'd1);
            check("stream_occ", {30'd0, occupancy}, 32'd1);
        end

        // 6. Drain to empty
        offer(1'b0, 32'd0, 1'b0);
        cycle();
        check("drain_valid", {31'd0, ID_valid}, 32'd0);
        check("drain_instr", ID_instruction, NOP);
        check("drain_pc", ID_pc, 32'd0);
        check("drain_occ", {30'd0, occupancy}, 32'd0);

        // 3. Back-pressure / skid
        ID_ready = 1'b0;
        offer(1'b1, 32'h1111_1110, 1'b0);
        cycle();
        check("bp_pc0", ID_pc, 32'h1111_1110);
        offer(1'b1, 32'h1111_1114, 1'b0);
        cycle();
        check("skid_occ", {30'd0, occupancy}, 32'd2);
        check("skid_ready", {31'd0, IF_ready}, 32'd0);
        check("skid_pc", ID_pc, 32'h1111_1110);
        offer(1'b1, 32'h1111_1118, 1'b0);
        ID_ready = 1'b1;
        cycle();
        check("skid_drain_pc", ID_pc, 32'h1111_1114);
        check("skid_drain_occ", {30'd0, occupancy}, 32'd1);
        check("skid_drain_ready", {31'd0, IF_ready}, 32'd1);
        cycle();
        check("skid_next_pc", ID_pc, 32'h1111_1118);

        // 4. Flush in SKID
        ID_ready = 1'b0;
        offer(1'b1, 32'h0000_3000, 1'b1);
        cycle();
        check("pre_flush_occ", {30'd0, occupancy}, 32'd2);
        flush = 1'b1;
        ID_ready = 1'b1;
        offer(1'b1, 32'h0000_3004, 1'b1);
        cycle();
        flush = 1'b0;
        check("flush_valid", {31'd0, ID_valid}, 32'd0);
        check("flush_instr", ID_instruction, NOP);
        check("flush_be", {31'd0, ID_branch_estimation}, 32'd0);
        check("flush_occ", {30'd0, occupancy}, 32'd0);
        check("flush_ready", {31'd0, IF_ready}, 32'd1);
        offer(1'b0, 32'd0, 1'b0);
        cycle();
        check("post_flush_valid", {31'd0, ID_valid}, 32'd0);
        // Flush while a beat is offered in EMPTY: beat is discarded.
        flush = 1'b1;
        offer(1'b1, 32'h0000_4000, 1'b0);
        cycle();
        flush = 1'b0;
        check("flush_empty_valid", {31'd0, ID_valid}, 32'd0);

        // 5. Simultaneous accept + drain with branch flag
        offer(1'b1, 32'h0000_1ffc, 1'b0);
        cycle();
        offer(1'b1, 32'h0000_2000, 1'b1);
        cycle();
        check("ad_pc", ID_pc, 32'h0000_2000);
        check("ad_pc4", ID_pc_plus_4, 32'h0000_2004);
        check("ad_be", {31'd0, ID_branch_estimation}, 32'd1);
        check("ad_occ", {30'd0, occupancy}, 32'd1);

        // Mid-cycle async reset while FULL
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, ID_valid}, 32'd0);
        check("arst_pc", ID_pc, 32'd0);
        check("arst_instr", ID_instruction, NOP);
        check("arst_occ", {30'd0, occupancy}, 32'd0);
        check("arst_ready", {31'd0, IF_ready}, 32'd1);
        #4 reset = 1'b0;
        offer(1'b0, 32'd0, 1'b0);
        cycle();

        // Mixed traffic, checked by the model every cycle
        for (int i = 0; i < 200; i++) begin
            offer($urandom_range(0, 3) != 0, $urandom, 1'($urandom));
            IF_instruction = $urandom;
            ID_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0;
        offer(1'b0, 32'd0, 1'b0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
